// File: rtl/controle_execucao.sv
// Execution controller: stalls the CPU on IN until a debounced button press,
// freezes it on HALT, latches the display on OUT and counts retired instructions.
module controle_execucao #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        botao,
   input  logic        OpIn,
   input  logic        OpOut,
   input  logic        OpHalt,
   input  logic [27:0] dado_saida,
   output logic        cpu_en,
   output logic [27:0] display,
   output logic        aguardando_entrada,
   output logic        parado,
   output logic [15:0] contador_instr
);

   localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_EXEC,
      S_ESPERA,
      S_LIBERA,
      S_HALT
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_sync_meta;
   logic        r_sync;
   logic        r_estavel;
   logic        r_estavel_d;
   logic [19:0] r_cnt;
   logic [27:0] r_display;
   logic [15:0] r_contador;
   logic        w_press;
   logic        w_cpu_en;

   // Button idles high (active-low), so the whole path resets to 1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
         r_estavel   <= 1'b1;
         r_estavel_d <= 1'b1;
         r_cnt       <= '0;
      end else begin
         r_sync_meta <= botao;
         r_sync      <= r_sync_meta;
         r_estavel_d <= r_estavel;
         if (r_sync == r_estavel) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_estavel <= r_sync;
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + 20'd1;
         end
      end
   end

   assign w_press = r_estavel_d & ~r_estavel;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_EXEC;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state       = r_state;
      w_cpu_en           = 1'b0;
      aguardando_entrada = 1'b0;
      parado             = 1'b0;
      case (r_state)
         S_EXEC: begin
            w_cpu_en = ~(OpIn | OpHalt);
            if (OpHalt) begin
               w_next_state = S_HALT;
            end else if (OpIn) begin
               w_next_state = S_ESPERA;
            end
         end
         S_ESPERA: begin
            aguardando_entrada = 1'b1;
            if (w_press) begin
               w_next_state = S_LIBERA;
            end
         end
         S_LIBERA: begin
            // The stalled IN retires here; its strobe is still high and must be ignored.
            w_cpu_en     = 1'b1;
            w_next_state = S_EXEC;
         end
         S_HALT: begin
            parado = 1'b1;
         end
         default: begin
            w_next_state = S_EXEC;
         end
      endcase
      if (!reset_n) begin
         w_cpu_en = 1'b0;
      end
   end

   assign cpu_en = w_cpu_en;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_display  <= '0;
         r_contador <= '0;
      end else begin
         if ((r_state == S_EXEC) && w_cpu_en && OpOut) begin
            r_display <= dado_saida;
         end
         if (w_cpu_en) begin
            r_contador <= r_contador + 16'd1;
         end
      end
   end

   assign display        = r_display;
   assign contador_instr = r_contador;

endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao: table of EXEC/OUT vectors plus
// hand sequences for IN stall, bounce, held button, HALT, priority and wrap.
module tb_controle_execucao;

   localparam int DEB = 4;

   logic        clock      = 1'b0;
   logic        reset_n    = 1'b0;
   logic        botao      = 1'b1;
   logic        OpIn       = 1'b0;
   logic        OpOut      = 1'b0;
   logic        OpHalt     = 1'b0;
   logic [27:0] dado_saida = '0;
   logic        cpu_en;
   logic [27:0] display;
   logic        aguardando_entrada;
   logic        parado;
   logic [15:0] contador_instr;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_cnt = '0;
   logic [27:0] exp_disp = '0;

   typedef struct {
      logic        op_out;
      logic [27:0] dado;
      logic        exp_en;
      logic [27:0] exp_disp;
   } vec_t;

   vec_t vecs[6];

   controle_execucao #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .botao              (botao),
      .OpIn               (OpIn),
      .OpOut              (OpOut),
      .OpHalt             (OpHalt),
      .dado_saida         (dado_saida),
      .cpu_en             (cpu_en),
      .display            (display),
      .aguardando_entrada (aguardando_entrada),
      .parado             (parado),
      .contador_instr     (contador_instr)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: check the combinational enable before the edge, the counter after it.
   task automatic step(input logic exp_en, input string name);
      #1;
      check({name, "_cpu_en"}, 32'(cpu_en), 32'(exp_en));
      @(posedge clock);
      #1;
      if (exp_en) exp_cnt = exp_cnt + 16'd1;
      check({name, "_contador"}, 32'(contador_instr), 32'(exp_cnt));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_cpu_en", 32'(cpu_en), 32'd0);
      check("rst_display", 32'(display), 32'd0);
      check("rst_contador", 32'(contador_instr), 32'd0);
      check("rst_parado", 32'(parado), 32'd0);
      check("rst_aguardando", 32'(aguardando_entrada), 32'd0);
      exp_cnt  = '0;
      exp_disp = '0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{1'b0, 28'h0000123, 1'b1, 28'h0000000};
      vecs[1] = '{1'b1, 28'h00ABCDE, 1'b1, 28'h00ABCDE};
      vecs[2] = '{1'b0, 28'hFFFFFFF, 1'b1, 28'h00ABCDE};
      vecs[3] = '{1'b1, 28'hFFFFFFF, 1'b1, 28'hFFFFFFF};
      vecs[4] = '{1'b1, 28'h0000001, 1'b1, 28'h0000001};
      vecs[5] = '{1'b0, 28'h5555555, 1'b1, 28'h0000001};

      // Reset held for several cycles with OpIn low
      repeat (3) @(posedge clock);
      #1;
      check("init_cpu_en", 32'(cpu_en), 32'd0);
      check("init_display", 32'(display), 32'd0);
      check("init_contador", 32'(contador_instr), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, "run");
      $display("[TB] reset release: contador=%0d", contador_instr);

      // EXEC / OUT table
      for (int i = 0; i < 6; i++) begin
         OpOut      = vecs[i].op_out;
         dado_saida = vecs[i].dado;
         step(vecs[i].exp_en, "vec");
         check("vec_display", 32'(display), 32'(vecs[i].exp_disp));
         $display("[TB] vec %0d out=%0b dado=%07h display=%07h contador=%0d",
                  i, vecs[i].op_out, vecs[i].dado, display, contador_instr);
      end
      exp_disp = vecs[5].exp_disp;
      OpOut    = 1'b0;

      // IN stall with a clean press: LIBERA comes after 7 edges
      OpIn = 1'b1;
      step(1'b0, "in_enter");
      check("in_aguardando", 32'(aguardando_entrada), 32'd1);
      botao = 1'b0;
      for (int i = 0; i < 6; i++) step(1'b0, "in_wait");
      check("in_still_waiting", 32'(aguardando_entrada), 32'd1);
      step(1'b0, "in_press");
      check("in_libera_aguardando", 32'(aguardando_entrada), 32'd0);
      step(1'b1, "in_libera");
      OpIn = 1'b0;
      step(1'b1, "in_next");
      $display("[TB] IN stall: contador=%0d", contador_instr);
      botao = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, "in_release");

      // Bounce rejection: toggling every 2 cycles never debounces
      OpIn = 1'b1;
      step(1'b0, "bnc_enter");
      for (int i = 0; i < 40; i++) begin
         botao = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         step(1'b0, "bnc_toggle");
      end
      check("bnc_aguardando", 32'(aguardando_entrada), 32'd1);
      botao = 1'b0;
      for (int i = 0; i < 7; i++) step(1'b0, "bnc_hold");
      step(1'b1, "bnc_libera");
      OpIn = 1'b0;
      step(1'b1, "bnc_next");
      $display("[TB] bounce: contador=%0d", contador_instr);
      botao = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, "bnc_release");

      // Held button: press happens in EXEC, must not carry into ESPERA
      botao = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, "held_pre");
      OpIn = 1'b1;
      for (int i = 0; i < 11; i++) step(1'b0, "held_wait");
      check("held_aguardando", 32'(aguardando_entrada), 32'd1);
      botao = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, "held_release");
      botao = 1'b0;
      for (int i = 0; i < 7; i++) step(1'b0, "held_press");
      step(1'b1, "held_libera");
      check("held_exec", 32'(aguardando_entrada), 32'd0);
      OpIn = 1'b0;
      step(1'b1, "held_next");
      $display("[TB] held button: contador=%0d", contador_instr);
      botao = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1, "held_idle");

      // HALT: 100 frozen cycles with presses and OUT attempts ignored
      OpHalt = 1'b1;
      step(1'b0, "halt_enter");
      check("halt_parado", 32'(parado), 32'd1);
      OpHalt     = 1'b0;
      OpOut      = 1'b1;
      dado_saida = 28'h1234567;
      for (int i = 0; i < 100; i++) begin
         botao = ((i / 10) % 2 == 0) ? 1'b1 : 1'b0;
         step(1'b0, "halt_hold");
      end
      check("halt_parado_end", 32'(parado), 32'd1);
      check("halt_display", 32'(display), 32'(exp_disp));
      $display("[TB] halt: parado=%0b display=%07h", parado, display);
      botao = 1'b1;
      OpOut = 1'b0;
      do_reset();
      step(1'b1, "halt_resume");

      // OpIn and OpHalt together: HALT wins
      OpIn   = 1'b1;
      OpHalt = 1'b1;
      step(1'b0, "prio");
      check("prio_parado", 32'(parado), 32'd1);
      check("prio_aguardando", 32'(aguardando_entrada), 32'd0);
      OpIn   = 1'b0;
      OpHalt = 1'b0;
      step(1'b0, "prio_stay");
      $display("[TB] priority: parado=%0b", parado);
      do_reset();

      // Counter wrap after 65535 retired instructions
      repeat (65535) @(posedge clock);
      #1;
      check("wrap_ffff", 32'(contador_instr), 32'h0000FFFF);
      @(posedge clock);
      #1;
      check("wrap_zero", 32'(contador_instr), 32'd0);
      $display("[TB] wrap: contador=%0d", contador_instr);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_execucao.md
# controle_execucao

Execution controller for the single-cycle `cpu`. It gates the CPU clock enable so that an `IN` instruction stalls until the operator confirms the switch value with a debounced push-button. It freezes the processor on `HALT` and registers the value shown on the 7-segment display on `OUT`. It sits between the board I/O (KEY button, HEX display) and the CPU, and consumes the `OpIn`/`OpOut`/`OpHalt` strobes from the control unit.

## Interface
- `DEBOUNCE_CYCLES`, default 50000 — consecutive stable samples required to accept a button level (1 ms at 50 MHz); legal range 2..2^20-1; internal counter is 20 bits.
- `clock`  in  1  — system clock; all state changes on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `botao`  in  1  — raw confirm push-button, active-low (0 = pressed), asynchronous to `clock`.
- `OpIn`  in  1  — current instruction is `IN`.
- `OpOut`  in  1  — current instruction is `OUT`.
- `OpHalt`  in  1  — current instruction is `HALT`.
- `dado_saida`  in  28  — value to display (register-file read port 2, bits 27:0).
- `cpu_en`  out  1  — clock enable for PC, register file and data-RAM write; combinational from state and strobes.
- `display`  out  28  — registered display value.
- `aguardando_entrada`  out  1  — high while waiting for the operator to confirm an `IN`.
- `parado`  out  1  — high in `HALT`.
- `contador_instr`  out  16  — count of retired instructions (cycles with `cpu_en`=1); wraps modulo 2^16.

## Operation
- Button path:
  - 2-FF synchronizer `sync` (reset value 1).
  - Debouncer with stable level `estavel` (reset 1) and counter `cnt` (reset 0).
    - If `sync`==`estavel`: `cnt`<=0.
    - Else `cnt`<=`cnt`+1.
    - When `cnt`==`DEBOUNCE_CYCLES`-1 with `sync`!=`estavel`: `estavel`<=`sync`, `cnt`<=0.
  - `estavel_d` registers `estavel` (reset 1).
  - Press event `press` = `estavel_d` & !`estavel`, a one-cycle pulse.
- States:
  - EXEC
    - `cpu_en` = !(`OpIn` | `OpHalt`).
    - `OpHalt` -> HALT. `OpHalt` has priority when both strobes are high.
    - Else `OpIn` -> ESPERA.
    - Else stay.
    - `press` is ignored here and is not queued.
  - ESPERA
    - `cpu_en`=0, `aguardando_entrada`=1.
    - On `press` -> LIBERA.
    - Only a press edge that occurs inside ESPERA counts. A button already held on entry must be released and pressed again.
  - LIBERA
    - `cpu_en`=1 for exactly one cycle; the stalled `IN` retires and writes the switches.
    - Strobes are ignored.
    - -> EXEC.
  - HALT
    - `cpu_en`=0, `parado`=1.
    - Terminal until `reset_n` asserts; `press` is ignored.
- Display: on a rising edge with `cpu_en`=1 and `OpOut`=1 in EXEC, `display`<=`dado_saida`; otherwise it holds.
- Counter: `contador_instr` increments on every rising edge with `cpu_en`=1; 16'hFFFF wraps to 0.

## Timing
- Reset values (`reset_n`=0, immediate):
  - state EXEC, `display`=0, `contador_instr`=0.
  - `sync`/`estavel`/`estavel_d`=1, `cnt`=0.
  - `aguardando_entrada`=0, `parado`=0.
  - `cpu_en` forced 0 while `reset_n`=0.
- Reset asserted mid-operation in any state aborts immediately to the reset values. After release, the CPU resumes from whatever the CPU's own reset leaves in its PC.
- Button latency: a raw transition held steady reaches `estavel` 2+`DEBOUNCE_CYCLES` edges later, and `press` follows one edge after that. Bounces shorter than `DEBOUNCE_CYCLES` cycles are rejected (`cnt` restarts).
- `IN` latency: the cycle after `press` is sampled in ESPERA is LIBERA (`cpu_en`=1). The next instruction executes in EXEC one cycle later.
- `OUT` is not stalled: `display` updates on the same edge the `OUT` instruction retires.
- `HALT` stalls from the cycle the strobe is seen; that instruction never retires (counter does not increment).

## Test plan
- Reset: hold `reset_n`=0 with `OpIn`=0 -> `cpu_en`=0, `display`=0, `contador_instr`=0. Release -> `cpu_en`=1 next cycle and the counter increments by 1 per cycle.
- `IN` stall (`DEBOUNCE_CYCLES`=4):
  - Assert `OpIn` -> `cpu_en`=0, ESPERA.
  - Drive `botao`=0 steady -> `press` after 7 edges; LIBERA gives a single `cpu_en`=1 cycle, then EXEC.
  - `contador_instr` increases by exactly 1 across the stall.
- Bounce rejection (`DEBOUNCE_CYCLES`=4): in ESPERA toggle `botao` every 2 cycles for 40 cycles -> no `press`, `cpu_en` stays 0. Then hold 0 -> release as above.
- Held button: enter ESPERA with `botao` already debounced low -> remains in ESPERA. Release then press -> exactly one LIBERA.
- `OUT`/`HALT`:
  - `OpOut` with `dado_saida`=28'h00ABCDE -> `display`=28'h00ABCDE next edge.
  - `OpHalt` -> `parado`=1, `cpu_en`=0 for 100 cycles with presses ignored; `reset_n` pulse returns to EXEC.
- Priority and wrap:
  - `OpIn`=`OpHalt`=1 -> HALT.
  - Preload 65535 retired cycles -> `contador_instr` wraps to 0.
